// File: rtl/ariane_axi_pkg.sv
// Purpose: minimal 64-bit AXI4 channel and bundle types shared by the peripheral
//          crossbar masters and slaves. Only the fields the crossbar carries are
//          modelled here.
// Contents:
//   - IdWidth / AddrWidth / DataWidth / UserWidth, the AXI response codes and
//     the burst type used by the single-beat masters.
//   - aw/w/b/ar/r channel structs.
//   - req_t  (master -> slave: aw, aw_valid, w, w_valid, b_ready, ar, ar_valid, r_ready).
//   - resp_t (slave -> master: aw_ready, ar_ready, w_ready, b_valid, b, r_valid, r).
package ariane_axi;

  localparam int unsigned IdWidth   = 4;
  localparam int unsigned AddrWidth = 64;
  localparam int unsigned DataWidth = 64;
  localparam int unsigned UserWidth = 1;
  localparam int unsigned StrbWidth = DataWidth / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_INCR = 2'b01;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [AddrWidth-1:0] addr;
    logic [7:0]           len;
    logic [2:0]           size;
    logic [1:0]           burst;
    logic                 lock;
    logic [3:0]           cache;
    logic [2:0]           prot;
    logic [3:0]           qos;
    logic [3:0]           region;
    logic [5:0]           atop;
    logic [UserWidth-1:0] user;
  } aw_chan_t;

  typedef struct packed {
    logic [DataWidth-1:0] data;
    logic [StrbWidth-1:0] strb;
    logic                 last;
    logic [UserWidth-1:0] user;
  } w_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [1:0]           resp;
    logic [UserWidth-1:0] user;
  } b_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [AddrWidth-1:0] addr;
    logic [7:0]           len;
    logic [2:0]           size;
    logic [1:0]           burst;
    logic                 lock;
    logic [3:0]           cache;
    logic [2:0]           prot;
    logic [3:0]           qos;
    logic [3:0]           region;
    logic [UserWidth-1:0] user;
  } ar_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [DataWidth-1:0] data;
    logic [1:0]           resp;
    logic                 last;
    logic [UserWidth-1:0] user;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } resp_t;

endpackage

// File: rtl/clint_arm_pkg.sv
// Purpose: definitions shared between the CLINT slave and the clint_timer_arm
//          master: command opcodes, master FSM states, CLINT register offsets and
//          helpers that build the MSIP write word/strobe.
// Contents:
//   - op_e     : RD_TIME, ARM_ABS, ARM_REL, SET_IPI, CLR_IPI
//   - state_e  : IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP
//   - MSIP_OFF / MTIMECMP_OFF / MTIME_OFF byte offsets from the CLINT base
//   - msipWord / msipStrb : MSIP write payload for a given hart
package clint_arm_pkg;

  typedef enum logic [2:0] {
    RD_TIME = 3'd0,
    ARM_ABS = 3'd1,
    ARM_REL = 3'd2,
    SET_IPI = 3'd3,
    CLR_IPI = 3'd4
  } op_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
    WR_RESP = 3'd4,
    RESP    = 3'd5
  } state_e;

  localparam logic [63:0] MSIP_OFF     = 64'h0000_0000;
  localparam logic [63:0] MTIMECMP_OFF = 64'h0000_4000;
  localparam logic [63:0] MTIME_OFF    = 64'h0000_BFF8;

  // MSIP registers are 32 bits wide, two per 64-bit beat: odd harts live in the
  // upper word, so the set bit moves to bit 32 and only the upper lanes are strobed.
  function automatic logic [63:0] msipWord(input logic hartOdd, input logic setBit);
    logic [63:0] word;
    word = '0;
    if (hartOdd) word[32] = setBit;
    else         word[0]  = setBit;
    return word;
  endfunction

  function automatic logic [7:0] msipStrb(input logic hartOdd);
    return hartOdd ? 8'hF0 : 8'h0F;
  endfunction

endpackage

// File: rtl/clint_timer_arm.sv
// Purpose: AXI4 master that lets non-core logic (DMA, debug, boot control) read
//          mtime, arm mtimecmp (absolute or relative to mtime) and set/clear msip
//          on the CLINT. One single-beat command in flight at a time.
// Parameters:
//   CLINT_BASE : byte base address of the CLINT
//   NR_CORES   : number of harts; cmd_hart_i >= NR_CORES is rejected
//   AXI_ID     : constant ID driven on AW and AR
// Ports:
//   clk_i, rst_ni            : clock, asynchronous active-low reset
//   cmd_valid_i/cmd_ready_o  : command handshake (ready only while idle)
//   cmd_op_i/hart_i/data_i   : opcode, target hart, absolute value or delta
//   rsp_valid_o/rsp_ready_i  : response handshake, response held until consumed
//   rsp_data_o/rsp_err_o     : mtime or written mtimecmp value; error flag
//   axi_req_o/axi_resp_i     : AXI4 master port
module clint_timer_arm
  import clint_arm_pkg::*;
#(
  parameter logic [63:0]                      CLINT_BASE = 64'h0200_0000,
  parameter int unsigned                      NR_CORES   = 1,
  parameter logic [ariane_axi::IdWidth-1:0]   AXI_ID     = '0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  op_e               cmd_op_i,
  input  logic [15:0]       cmd_hart_i,
  input  logic [63:0]       cmd_data_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [63:0]       rsp_data_o,
  output logic              rsp_err_o,
  output ariane_axi::req_t  axi_req_o,
  input  ariane_axi::resp_t axi_resp_i
);

  state_e      r_state;
  op_e         r_op;
  logic [15:0] r_hart;
  logic [63:0] r_value;
  logic        r_cmdReady;
  logic        r_rspValid;
  logic [63:0] r_rspData;
  logic        r_rspErr;
  logic        r_arValid;
  logic        r_rReady;
  logic        r_awValid;
  logic        r_wValid;
  logic        r_bReady;

  logic        w_isArm;
  logic [63:0] w_wrAddr;
  logic [63:0] w_wrData;
  logic [7:0]  w_wrStrb;
  logic        w_badHart;
  logic        w_unused;

  assign w_badHart = (32'(cmd_hart_i) >= NR_CORES);

  // Write payload is derived purely from latched command state, so it cannot
  // move while aw_valid/w_valid are up.
  always_comb begin
    w_isArm  = (r_op == ARM_ABS) || (r_op == ARM_REL);
    w_wrAddr = CLINT_BASE + MSIP_OFF + {46'd0, r_hart, 2'd0};
    w_wrData = msipWord(r_hart[0], r_op == SET_IPI);
    w_wrStrb = msipStrb(r_hart[0]);
    if (w_isArm) begin
      w_wrAddr = CLINT_BASE + MTIMECMP_OFF + {45'd0, r_hart, 3'd0};
      w_wrData = r_value;
      w_wrStrb = 8'hFF;
    end
  end

  always_comb begin
    axi_req_o             = '0;
    axi_req_o.ar.id       = AXI_ID;
    axi_req_o.ar.addr     = CLINT_BASE + MTIME_OFF;
    axi_req_o.ar.len      = 8'd0;
    axi_req_o.ar.size     = 3'd3;
    axi_req_o.ar.burst    = ariane_axi::BURST_INCR;
    axi_req_o.ar_valid    = r_arValid;
    axi_req_o.r_ready     = r_rReady;
    axi_req_o.aw.id       = AXI_ID;
    axi_req_o.aw.addr     = w_wrAddr;
    axi_req_o.aw.len      = 8'd0;
    axi_req_o.aw.size     = 3'd3;
    axi_req_o.aw.burst    = ariane_axi::BURST_INCR;
    axi_req_o.aw_valid    = r_awValid;
    axi_req_o.w.data      = w_wrData;
    axi_req_o.w.strb      = w_wrStrb;
    axi_req_o.w.last      = 1'b1;
    axi_req_o.w_valid     = r_wValid;
    axi_req_o.b_ready     = r_bReady;
  end

  assign cmd_ready_o = r_cmdReady;
  assign rsp_valid_o = r_rspValid;
  assign rsp_data_o  = r_rspData;
  assign rsp_err_o   = r_rspErr;

  // Single-beat responses make these slave fields irrelevant to the master.
  assign w_unused = ^{axi_resp_i.r.id, axi_resp_i.r.last, axi_resp_i.r.user,
                      axi_resp_i.b.id, axi_resp_i.b.user};

  // Command FSM. Every AXI valid/ready and response output is a flop updated
  // on the transition into the state that owns it. Errors go straight to RESP,
  // so a failed ARM_REL read never reaches the write phase.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= IDLE;
      r_op       <= RD_TIME;
      r_hart     <= '0;
      r_value    <= '0;
      r_cmdReady <= 1'b1;
      r_rspValid <= 1'b0;
      r_rspData  <= '0;
      r_rspErr   <= 1'b0;
      r_arValid  <= 1'b0;
      r_rReady   <= 1'b0;
      r_awValid  <= 1'b0;
      r_wValid   <= 1'b0;
      r_bReady   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (cmd_valid_i) begin
            r_op       <= cmd_op_i;
            r_hart     <= cmd_hart_i;
            r_value    <= cmd_data_i;
            r_cmdReady <= 1'b0;
            if (w_badHart) begin
              r_state    <= RESP;
              r_rspValid <= 1'b1;
              r_rspErr   <= 1'b1;
              r_rspData  <= '0;
            end else begin
              case (cmd_op_i)
                RD_TIME, ARM_REL: begin
                  r_state   <= RD_ADDR;
                  r_arValid <= 1'b1;
                end
                ARM_ABS, SET_IPI, CLR_IPI: begin
                  r_state   <= WR_REQ;
                  r_awValid <= 1'b1;
                  r_wValid  <= 1'b1;
                end
                default: begin
                  // Undefined opcodes are refused without touching the bus.
                  r_state    <= RESP;
                  r_rspValid <= 1'b1;
                  r_rspErr   <= 1'b1;
                  r_rspData  <= '0;
                end
              endcase
            end
          end
        end

        RD_ADDR: begin
          if (axi_resp_i.ar_ready) begin
            r_arValid <= 1'b0;
            r_rReady  <= 1'b1;
            r_state   <= RD_DATA;
          end
        end

        RD_DATA: begin
          if (axi_resp_i.r_valid) begin
            r_rReady <= 1'b0;
            if (axi_resp_i.r.resp != ariane_axi::RESP_OKAY) begin
              r_state    <= RESP;
              r_rspValid <= 1'b1;
              r_rspErr   <= 1'b1;
              r_rspData  <= '0;
            end else if (r_op == RD_TIME) begin
              r_state    <= RESP;
              r_rspValid <= 1'b1;
              r_rspErr   <= 1'b0;
              r_rspData  <= axi_resp_i.r.data;
            end else begin
              // ARM_REL: deadline wraps modulo 2^64 like mtime itself.
              r_value   <= axi_resp_i.r.data + r_value;
              r_state   <= WR_REQ;
              r_awValid <= 1'b1;
              r_wValid  <= 1'b1;
            end
          end
        end

        WR_REQ: begin
          // AW and W complete independently; leave once neither is pending.
          if (axi_resp_i.aw_ready) r_awValid <= 1'b0;
          if (axi_resp_i.w_ready)  r_wValid  <= 1'b0;
          if ((!r_awValid || axi_resp_i.aw_ready) && (!r_wValid || axi_resp_i.w_ready)) begin
            r_state  <= WR_RESP;
            r_bReady <= 1'b1;
          end
        end

        WR_RESP: begin
          if (axi_resp_i.b_valid) begin
            r_bReady   <= 1'b0;
            r_state    <= RESP;
            r_rspValid <= 1'b1;
            if (axi_resp_i.b.resp != ariane_axi::RESP_OKAY) begin
              r_rspErr  <= 1'b1;
              r_rspData <= '0;
            end else begin
              r_rspErr  <= 1'b0;
              r_rspData <= w_isArm ? r_value : 64'd0;
            end
          end
        end

        RESP: begin
          if (rsp_ready_i) begin
            r_rspValid <= 1'b0;
            r_rspErr   <= 1'b0;
            r_rspData  <= '0;
            r_cmdReady <= 1'b1;
            r_state    <= IDLE;
          end
        end

        default: begin
          r_state    <= IDLE;
          r_cmdReady <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clint_timer_arm.sv
// Purpose: self-checking bench for clint_timer_arm (NR_CORES=2) against a
//          reactive zero-wait AXI slave with configurable ready skew and
//          response codes. Expected responses and bus transactions are queued
//          when a command is issued and compared when the response appears.
module tb_clint_timer_arm;
  import clint_arm_pkg::*;

  localparam logic [63:0] BASE = 64'h0200_0000;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              cmd_valid_i;
  logic              cmd_ready_o;
  op_e               cmd_op_i;
  logic [15:0]       cmd_hart_i;
  logic [63:0]       cmd_data_i;
  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [63:0]       rsp_data_o;
  logic              rsp_err_o;
  ariane_axi::req_t  axi_req;
  ariane_axi::resp_t axi_resp = '0;

  always #5 clk_i = ~clk_i;

  clint_timer_arm #(
    .CLINT_BASE (BASE),
    .NR_CORES   (2),
    .AXI_ID     ('0)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_op_i    (cmd_op_i),
    .cmd_hart_i  (cmd_hart_i),
    .cmd_data_i  (cmd_data_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_data_o  (rsp_data_o),
    .rsp_err_o   (rsp_err_o),
    .axi_req_o   (axi_req),
    .axi_resp_i  (axi_resp)
  );

  typedef struct {
    logic [63:0] data;
    bit          chkData;
    logic        err;
    int          lat;
    int          nAr;
    logic [63:0] arAddr;
    int          nWr;
    logic [63:0] wrAddr;
    logic [63:0] wrData;
    logic [7:0]  wrStrb;
  } exp_t;

  exp_t expQ[$];
  int   total = 0;
  int   bad   = 0;

  // Slave model configuration and observations.
  logic [63:0] mtimeVal  = '0;
  logic [1:0]  rRespCode = 2'b00;
  logic [1:0]  bRespCode = 2'b00;
  bit          randomReady = 0;
  bit          holdAw = 0;
  int          arCount, awCount, wCount, unstable;
  bit          anyValid;
  logic [63:0] arAddrSeen, awAddrSeen, wDataSeen;
  logic [7:0]  wStrbSeen;
  bit          pendR, pendB, gotAw, gotW, awWait, wWait;
  logic [63:0] prevAwAddr, prevWData;
  logic [7:0]  prevWStrb;

  // Readies/valids change on the falling edge and are stable through the next
  // rising edge, as are the DUT outputs, so a handshake decided here is exactly
  // the one the DUT sees at the following rising edge.
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      axi_resp = '0;
      pendR = 0; pendB = 0; gotAw = 0; gotW = 0; awWait = 0; wWait = 0;
    end else begin
      axi_resp.r_valid  = pendR;
      axi_resp.r.data   = mtimeVal;
      axi_resp.r.resp   = rRespCode;
      axi_resp.r.last   = 1'b1;
      if (pendR && axi_req.r_ready) pendR = 0;
      axi_resp.b_valid  = pendB;
      axi_resp.b.resp   = bRespCode;
      if (pendB && axi_req.b_ready) pendB = 0;
      axi_resp.ar_ready = 1'b1;
      if (axi_req.ar_valid) begin
        anyValid = 1; arCount++; arAddrSeen = axi_req.ar.addr; pendR = 1;
      end
      axi_resp.aw_ready = randomReady ? 1'($urandom_range(0, 1)) : !holdAw;
      axi_resp.w_ready  = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
      if (axi_req.aw_valid) begin
        anyValid = 1;
        if (awWait && axi_req.aw.addr !== prevAwAddr) unstable++;
        if (axi_resp.aw_ready) begin
          awCount++; awAddrSeen = axi_req.aw.addr; gotAw = 1; awWait = 0;
        end else begin
          awWait = 1; prevAwAddr = axi_req.aw.addr;
        end
      end
      if (axi_req.w_valid) begin
        anyValid = 1;
        if (wWait && (axi_req.w.data !== prevWData || axi_req.w.strb !== prevWStrb)) unstable++;
        if (axi_resp.w_ready) begin
          wCount++; wDataSeen = axi_req.w.data; wStrbSeen = axi_req.w.strb; gotW = 1; wWait = 0;
        end else begin
          wWait = 1; prevWData = axi_req.w.data; prevWStrb = axi_req.w.strb;
        end
      end
      if (gotAw && gotW) begin
        pendB = 1; gotAw = 0; gotW = 0;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clearCounters();
    arCount = 0; awCount = 0; wCount = 0; unstable = 0; anyValid = 0;
  endtask

  function automatic exp_t mkExp(input logic [63:0] data, input bit chkData, input logic err,
                                 input int lat, input int nAr, input int nWr,
                                 input logic [63:0] wrAddr, input logic [63:0] wrData,
                                 input logic [7:0] wrStrb);
    exp_t e;
    e.data = data; e.chkData = chkData; e.err = err; e.lat = lat;
    e.nAr = nAr; e.arAddr = 64'h0200_BFF8; e.nWr = nWr;
    e.wrAddr = wrAddr; e.wrData = wrData; e.wrStrb = wrStrb;
    return e;
  endfunction

  // Issue one command, wait for its response, compare it against the head of
  // the scoreboard, hold rsp_ready low for holdCycles, then consume it.
  task automatic applyStimulus(input string name, input op_e op, input logic [15:0] hart,
                               input logic [63:0] data, input exp_t e, input int holdCycles);
    int          lat;
    exp_t        x;
    logic [63:0] heldData;
    logic        heldErr;
    #1 clearCounters();
    expQ.push_back(e);
    @(negedge clk_i);
    checkOutput({name, "_cmd_ready_idle"}, 64'(cmd_ready_o), 64'd1);
    cmd_op_i = op; cmd_hart_i = hart; cmd_data_i = data; cmd_valid_i = 1'b1;
    @(posedge clk_i);
    #1 cmd_valid_i = 1'b0;
    lat = 1;
    @(negedge clk_i);
    while (!rsp_valid_o && lat < 60) begin
      @(negedge clk_i);
      lat++;
    end
    checkOutput({name, "_rsp_valid"}, 64'(rsp_valid_o), 64'd1);
    x = expQ.pop_front();
    checkOutput({name, "_err"}, 64'(rsp_err_o), 64'(x.err));
    if (x.chkData) checkOutput({name, "_data"}, rsp_data_o, x.data);
    if (x.lat > 0) checkOutput({name, "_latency"}, 64'(lat), 64'(x.lat));
    checkOutput({name, "_ar_count"}, 64'(arCount), 64'(x.nAr));
    if (x.nAr > 0) checkOutput({name, "_ar_addr"}, arAddrSeen, x.arAddr);
    checkOutput({name, "_aw_count"}, 64'(awCount), 64'(x.nWr));
    checkOutput({name, "_w_count"}, 64'(wCount), 64'(x.nWr));
    if (x.nWr > 0) begin
      checkOutput({name, "_aw_addr"}, awAddrSeen, x.wrAddr);
      checkOutput({name, "_w_data"}, wDataSeen, x.wrData);
      checkOutput({name, "_w_strb"}, 64'(wStrbSeen), 64'(x.wrStrb));
      checkOutput({name, "_payload_stable"}, 64'(unstable), 64'd0);
    end
    checkOutput({name, "_cmd_ready_busy"}, 64'(cmd_ready_o), 64'd0);
    heldData = rsp_data_o;
    heldErr  = rsp_err_o;
    for (int i = 0; i < holdCycles; i++) begin
      @(negedge clk_i);
      checkOutput({name, "_hold_valid"}, 64'(rsp_valid_o), 64'd1);
      checkOutput({name, "_hold_data"}, rsp_data_o, heldData);
      checkOutput({name, "_hold_err"}, 64'(rsp_err_o), 64'(heldErr));
    end
    rsp_ready_i = 1'b1;
    @(posedge clk_i);
    #1 rsp_ready_i = 1'b0;
    @(negedge clk_i);
    checkOutput({name, "_rsp_dropped"}, 64'(rsp_valid_o), 64'd0);
    checkOutput({name, "_cmd_ready_back"}, 64'(cmd_ready_o), 64'd1);
  endtask

  initial begin
    logic [15:0] h;
    logic [63:0] d;
    rst_ni = 1'b0; cmd_valid_i = 1'b0; cmd_op_i = RD_TIME; cmd_hart_i = '0;
    cmd_data_i = '0; rsp_ready_i = 1'b0;
    clearCounters();
    repeat (3) @(negedge clk_i);
    checkOutput("reset_cmd_ready", 64'(cmd_ready_o), 64'd1);
    checkOutput("reset_rsp_valid", 64'(rsp_valid_o), 64'd0);
    checkOutput("reset_rsp_data", rsp_data_o, 64'd0);
    checkOutput("reset_rsp_err", 64'(rsp_err_o), 64'd0);
    checkOutput("reset_axi_valids",
                64'({axi_req.ar_valid, axi_req.aw_valid, axi_req.w_valid, axi_req.r_ready, axi_req.b_ready}),
                64'd0);
    #2 rst_ni = 1'b1;

    $display("[TB] directed commands");
    mtimeVal = 64'h1234;
    applyStimulus("rd_time", RD_TIME, 16'd0, 64'd0,
                  mkExp(64'h1234, 1, 0, 3, 1, 0, 64'd0, 64'd0, 8'h00), 10);
    applyStimulus("arm_abs_h1", ARM_ABS, 16'd1, 64'hDEAD_BEEF_0000_1000,
                  mkExp(64'hDEAD_BEEF_0000_1000, 1, 0, 3, 0, 1, 64'h0200_4008,
                        64'hDEAD_BEEF_0000_1000, 8'hFF), 0);
    mtimeVal = 64'hFFFF_FFFF_FFFF_FFF0;
    applyStimulus("arm_rel_wrap", ARM_REL, 16'd1, 64'd100,
                  mkExp(64'h54, 1, 0, 5, 1, 1, 64'h0200_4008, 64'h54, 8'hFF), 0);
    mtimeVal = 64'h1000;
    applyStimulus("arm_rel_h0", ARM_REL, 16'd0, 64'h10,
                  mkExp(64'h1010, 1, 0, 5, 1, 1, 64'h0200_4000, 64'h1010, 8'hFF), 0);
    applyStimulus("set_ipi_h1", SET_IPI, 16'd1, 64'd0,
                  mkExp(64'd0, 1, 0, 3, 0, 1, 64'h0200_0004, 64'h1_0000_0000, 8'hF0), 0);
    applyStimulus("set_ipi_h0", SET_IPI, 16'd0, 64'd0,
                  mkExp(64'd0, 1, 0, 3, 0, 1, 64'h0200_0000, 64'h1, 8'h0F), 0);
    applyStimulus("clr_ipi_h0", CLR_IPI, 16'd0, 64'hFFFF,
                  mkExp(64'd0, 1, 0, 3, 0, 1, 64'h0200_0000, 64'h0, 8'h0F), 0);
    applyStimulus("clr_ipi_h1", CLR_IPI, 16'd1, 64'd0,
                  mkExp(64'd0, 1, 0, 3, 0, 1, 64'h0200_0004, 64'h0, 8'hF0), 0);

    $display("[TB] error paths");
    applyStimulus("bad_hart", ARM_ABS, 16'd5, 64'h55,
                  mkExp(64'd0, 0, 1, 1, 0, 0, 64'd0, 64'd0, 8'h00), 0);
    checkOutput("bad_hart_no_valid", 64'(anyValid), 64'd0);
    rRespCode = ariane_axi::RESP_SLVERR;
    applyStimulus("arm_rel_slverr", ARM_REL, 16'd0, 64'd7,
                  mkExp(64'd0, 0, 1, 3, 1, 0, 64'd0, 64'd0, 8'h00), 0);
    applyStimulus("rd_time_slverr", RD_TIME, 16'd1, 64'd0,
                  mkExp(64'd0, 0, 1, 3, 1, 0, 64'd0, 64'd0, 8'h00), 0);
    rRespCode = ariane_axi::RESP_OKAY;
    bRespCode = ariane_axi::RESP_DECERR;
    applyStimulus("arm_abs_decerr", ARM_ABS, 16'd0, 64'h77,
                  mkExp(64'd0, 0, 1, 3, 0, 1, 64'h0200_4000, 64'h77, 8'hFF), 0);
    bRespCode = ariane_axi::RESP_OKAY;

    $display("[TB] random aw/w ready skew");
    randomReady = 1;
    for (int i = 0; i < 8; i++) begin
      h = 16'($urandom_range(0, 1));
      d = {$urandom, $urandom};
      applyStimulus("skew_arm_abs", ARM_ABS, h, d,
                    mkExp(d, 1, 0, 0, 0, 1, 64'h0200_4000 + 64'(h) * 8, d, 8'hFF), 0);
    end
    randomReady = 0;

    $display("[TB] reset during write request");
    holdAw = 1;
    #1 clearCounters();
    @(negedge clk_i);
    cmd_op_i = ARM_ABS; cmd_hart_i = 16'd0; cmd_data_i = 64'h99; cmd_valid_i = 1'b1;
    @(posedge clk_i);
    #1 cmd_valid_i = 1'b0;
    @(negedge clk_i);
    checkOutput("rst_mid_aw_valid_before", 64'(axi_req.aw_valid), 64'd1);
    #2 rst_ni = 1'b0;
    #1;
    checkOutput("rst_mid_valids",
                64'({axi_req.ar_valid, axi_req.aw_valid, axi_req.w_valid, axi_req.r_ready, axi_req.b_ready}),
                64'd0);
    checkOutput("rst_mid_cmd_ready", 64'(cmd_ready_o), 64'd1);
    checkOutput("rst_mid_rsp_valid", 64'(rsp_valid_o), 64'd0);
    @(negedge clk_i);
    #2 rst_ni = 1'b1;
    holdAw = 0;
    mtimeVal = 64'hABCD;
    applyStimulus("rd_time_after_rst", RD_TIME, 16'd0, 64'd0,
                  mkExp(64'hABCD, 1, 0, 3, 1, 0, 64'd0, 64'd0, 8'h00), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
